// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and types for the data memory responder
package mem_pkg;

  localparam int BE_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_align.sv
// rtl/data_mem_align.sv - lane select, extension, byte enables and alignment fault
module data_mem_align
  import mem_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [31:0]     raw_word,
  input  logic [31:0]     store_data,
  output logic [31:0]     load_data,
  output logic [BE_W-1:0] byte_en,
  output logic [31:0]     store_word,
  output logic            fault
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // pick the addressed byte and halfword out of the raw word
  always_comb begin
    byte_sel = raw_word[7:0];
    case (addr_lo)
      2'd0: byte_sel = raw_word[7:0];
      2'd1: byte_sel = raw_word[15:8];
      2'd2: byte_sel = raw_word[23:16];
      2'd3: byte_sel = raw_word[31:24];
      default: byte_sel = raw_word[7:0];
    endcase
    half_sel = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
  end

  // size decode: extension, lane enables, replicated store data, misalignment
  always_comb begin
    load_data  = 32'h0;
    byte_en    = '0;
    store_word = store_data;
    fault      = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        load_data  = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
        byte_en    = 4'b0001 << addr_lo;
        store_word = {4{store_data[7:0]}};
      end
      F3_H, F3_HU: begin
        load_data  = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_word = {2{store_data[15:0]}};
        fault      = addr_lo[0];
      end
      F3_W: begin
        load_data  = raw_word;
        byte_en    = 4'b1111;
        store_word = store_data;
        fault      = |addr_lo;
      end
      default: begin
        fault = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// rtl/data_mem.sv - fixed-latency data memory responder for the MEM stage
module data_mem
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_memread,
  input  logic        MEM_memwrite,
  input  logic [2:0]  MEM_funct3,
  input  logic [31:0] MEM_ALU_result,
  input  logic [31:0] MEM_rs2_data,
  output logic [31:0] data_mem_read_data,
  output logic        data_mem_stall,
  output logic        data_mem_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [31:0] mem [DEPTH_WORDS];

  state_t          state;
  logic [3:0]      cnt;
  logic            req;
  logic            is_store;
  logic [AW-1:0]   idx;
  logic [31:0]     raw_word;
  logic [31:0]     load_data;
  logic [BE_W-1:0] byte_en;
  logic [31:0]     store_word;
  logic            align_fault;
  logic            acc_fault;
  logic [31:0]     cap_data;

  logic [AW-1:0]   pend_idx;
  logic [BE_W-1:0] pend_be;
  logic [31:0]     pend_wdata;
  logic            pend_we;

  logic            unused_addr_hi;

  assign req      = MEM_memread | MEM_memwrite;
  assign is_store = MEM_memwrite;
  assign idx      = MEM_ALU_result[AW+1:2];
  assign raw_word = mem[idx];
  assign unused_addr_hi = ^MEM_ALU_result[31:AW+2];

  data_mem_align u_align (
    .funct3     (MEM_funct3),
    .addr_lo    (MEM_ALU_result[1:0]),
    .raw_word   (raw_word),
    .store_data (MEM_rs2_data),
    .load_data  (load_data),
    .byte_en    (byte_en),
    .store_word (store_word),
    .fault      (align_fault)
  );

  // unsigned sizes are load-only, so a store using one is illegal
  assign acc_fault = align_fault | (is_store & MEM_funct3[2]);
  assign cap_data  = (is_store | acc_fault) ? 32'h0 : load_data;

  // hold the pipeline while an access is pending; reset releases it at once
  always_comb begin
    data_mem_stall = 1'b0;
    case (state)
      IDLE:    data_mem_stall = req & reset;
      WAIT:    data_mem_stall = reset;
      default: data_mem_stall = 1'b0;
    endcase
  end

  // access sequencing with capture of the result and of any pending store
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      cnt                <= 4'd0;
      data_mem_read_data <= 32'h0;
      data_mem_fault     <= 1'b0;
      pend_idx           <= '0;
      pend_be            <= '0;
      pend_wdata         <= 32'h0;
      pend_we            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && LATENCY == 1) begin
            data_mem_read_data <= cap_data;
            data_mem_fault     <= acc_fault;
            pend_idx           <= idx;
            pend_be            <= byte_en;
            pend_wdata         <= store_word;
            pend_we            <= is_store & ~acc_fault;
            state              <= DONE;
          end else if (req) begin
            cnt   <= 4'd1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
          end else if (cnt == LAT_M1) begin
            data_mem_read_data <= cap_data;
            data_mem_fault     <= acc_fault;
            pend_idx           <= idx;
            pend_be            <= byte_en;
            pend_wdata         <= store_word;
            pend_we            <= is_store & ~acc_fault;
            state              <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          pend_we <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // store commit on the edge that leaves DONE; contents survive reset
  always_ff @(posedge clk) begin
    if (state == DONE && pend_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (pend_be[i]) mem[pend_idx][8*i +: 8] <= pend_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - directed self-checking bench for data_mem
module tb_data_mem;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        MEM_memread;
  logic        MEM_memwrite;
  logic [2:0]  MEM_funct3;
  logic [31:0] MEM_ALU_result;
  logic [31:0] MEM_rs2_data;
  logic [31:0] data_mem_read_data;
  logic        data_mem_stall;
  logic        data_mem_fault;

  data_mem #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
    .clk                (clk),
    .reset              (reset),
    .MEM_memread        (MEM_memread),
    .MEM_memwrite       (MEM_memwrite),
    .MEM_funct3         (MEM_funct3),
    .MEM_ALU_result     (MEM_ALU_result),
    .MEM_rs2_data       (MEM_rs2_data),
    .data_mem_read_data (data_mem_read_data),
    .data_mem_stall     (data_mem_stall),
    .data_mem_fault     (data_mem_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // per-cycle expectations set by the driver, checked on the falling edge
  logic        exp_valid = 1'b0;
  logic        exp_stall = 1'b0;
  logic        exp_chk   = 1'b0;
  logic [31:0] exp_data  = 32'h0;
  logic        exp_fault = 1'b0;
  logic        lit_en    = 1'b0;
  logic [31:0] lit_data  = 32'h0;
  logic        lit_fault = 1'b0;

  // model state: byte-addressed memory image and last completed result
  logic [7:0]  mbytes [4096];
  logic [31:0] last_data  = 32'h0;
  logic        last_fault = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      chk("stall", 32'(data_mem_stall), 32'(exp_stall));
      if (exp_chk) begin
        chk("read_data", data_mem_read_data, exp_data);
        chk("fault", 32'(data_mem_fault), 32'(exp_fault));
      end
      if (lit_en) begin
        chk("lit_read_data", data_mem_read_data, lit_data);
        chk("lit_fault", 32'(data_mem_fault), 32'(lit_fault));
      end
    end
  end

  function automatic logic model_fault(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    logic f;
    f = 1'b0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) f = 1'b1;
    if (wr && f3 >= 3'd4) f = 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) f = 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'd0) f = 1'b1;
    return f;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int b;
    int v;
    b = int'(a[11:0]);
    v = 0;
    case (f3)
      3'd0: begin v = int'(mbytes[b]); if (v >= 128) v = v - 256; end
      3'd4: v = int'(mbytes[b]);
      3'd1: begin v = int'(mbytes[b]) + 256 * int'(mbytes[b+1]); if (v >= 32768) v = v - 65536; end
      3'd5: v = int'(mbytes[b]) + 256 * int'(mbytes[b+1]);
      3'd2: v = int'({mbytes[b+3], mbytes[b+2], mbytes[b+1], mbytes[b]});
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int b;
    int n;
    b = int'(a[11:0]);
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) mbytes[b + i] = d[8*i +: 8];
  endtask

  task automatic idle(input int n);
    MEM_memread  = 1'b0;
    MEM_memwrite = 1'b0;
    for (int k = 0; k < n; k++) begin
      exp_valid = 1'b1; exp_stall = 1'b0; exp_chk = 1'b1;
      exp_data = last_data; exp_fault = last_fault; lit_en = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // one access: LAT stalled cycles then one DONE cycle, inputs held throughout
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic use_lit, input logic [31:0] ld, input logic lf);
    logic        ef;
    logic [31:0] ed;
    ef = model_fault(wr, f3, a);
    ed = (wr || ef) ? 32'h0 : model_load(f3, a);
    MEM_memread = rd; MEM_memwrite = wr; MEM_funct3 = f3;
    MEM_ALU_result = a; MEM_rs2_data = d;
    for (int k = 0; k <= LAT; k++) begin
      exp_valid = 1'b1;
      exp_stall = (k < LAT);
      exp_chk   = (k == LAT);
      exp_data  = ed; exp_fault = ef;
      lit_en    = use_lit && (k == LAT);
      lit_data  = ld; lit_fault = lf;
      @(posedge clk); #1;
    end
    lit_en = 1'b0;
    if (wr && !ef) model_store(f3, a, d);
    last_data = ed; last_fault = ef;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mbytes[i] = 8'h00;
    reset = 1'b0; MEM_memread = 1'b0; MEM_memwrite = 1'b0;
    MEM_funct3 = 3'd0; MEM_ALU_result = 32'h0; MEM_rs2_data = 32'h0;
    exp_valid = 1'b1; exp_stall = 1'b0; exp_chk = 1'b1; exp_data = 32'h0; exp_fault = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle(2);

    // preload words used later
    access(1'b0, 1'b1, 3'd2, 32'h10, 32'h0000_0000, 1'b0, 32'h0, 1'b0);
    access(1'b0, 1'b1, 3'd2, 32'h40, 32'h1122_3344, 1'b1, 32'h0, 1'b0);
    idle(1);

    // reset in the middle of WAIT for a store: released at once, store dropped
    MEM_memread = 1'b0; MEM_memwrite = 1'b1; MEM_funct3 = 3'd2;
    MEM_ALU_result = 32'h10; MEM_rs2_data = 32'hDEAD_BEEF;
    exp_stall = 1'b1; exp_chk = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    exp_stall = 1'b0; exp_chk = 1'b1; exp_data = 32'h0; exp_fault = 1'b0;
    last_data = 32'h0; last_fault = 1'b0;
    @(posedge clk); #1;
    MEM_memwrite = 1'b0;
    reset = 1'b1;
    idle(2);
    access(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'h0000_0000, 1'b0);

    // byte lanes and sign/zero extension
    access(1'b0, 1'b1, 3'd2, 32'h20, 32'h80FF_7F01, 1'b0, 32'h0, 1'b0);
    access(1'b1, 1'b0, 3'd0, 32'h20, 32'h0, 1'b1, 32'h0000_0001, 1'b0);
    access(1'b1, 1'b0, 3'd0, 32'h21, 32'h0, 1'b1, 32'h0000_007F, 1'b0);
    access(1'b1, 1'b0, 3'd0, 32'h23, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0);
    access(1'b1, 1'b0, 3'd4, 32'h23, 32'h0, 1'b1, 32'h0000_0080, 1'b0);

    // halfword store into the upper half, neighbours untouched
    access(1'b0, 1'b1, 3'd1, 32'h42, 32'h0000_BEEF, 1'b0, 32'h0, 1'b0);
    access(1'b1, 1'b0, 3'd5, 32'h42, 32'h0, 1'b1, 32'h0000_BEEF, 1'b0);
    access(1'b1, 1'b0, 3'd1, 32'h42, 32'h0, 1'b1, 32'hFFFF_BEEF, 1'b0);
    access(1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 1'b1, 32'hBEEF_3344, 1'b0);

    // faults: misaligned load, misaligned store, unsigned-size store, illegal funct3
    access(1'b1, 1'b0, 3'd2, 32'h41, 32'h0, 1'b1, 32'h0, 1'b1);
    access(1'b0, 1'b1, 3'd2, 32'h42, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b1);
    access(1'b0, 1'b1, 3'd4, 32'h40, 32'h0000_0055, 1'b1, 32'h0, 1'b1);
    access(1'b1, 1'b0, 3'd3, 32'h40, 32'h0, 1'b1, 32'h0, 1'b1);
    access(1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 1'b1, 32'hBEEF_3344, 1'b0);
    idle(1);

    // flush: request dropped after one cycle, no DONE, outputs hold
    MEM_memread = 1'b1; MEM_funct3 = 3'd2; MEM_ALU_result = 32'h20;
    exp_stall = 1'b1; exp_chk = 1'b1; exp_data = last_data; exp_fault = last_fault;
    @(posedge clk); #1;
    MEM_memread = 1'b0;
    exp_stall = 1'b1;
    @(posedge clk); #1;
    idle(3);

    // back-to-back store then load, plus an aliased address
    access(1'b0, 1'b1, 3'd2, 32'h100, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
    access(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
    access(1'b1, 1'b0, 3'd2, 32'h1100, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
    access(1'b0, 1'b1, 3'd0, 32'h1103, 32'h0000_00A5, 1'b0, 32'h0, 1'b0);
    access(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 1'b1, 32'hA534_5678, 1'b0);
    idle(2);

    exp_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
